// File: rtl/dvd_motion_ctrl.sv
// Bouncing-tile motion sequencer: counts frame ticks, steps the tile with wall bounces,
// and accepts runtime position/direction loads while idle.
module dvd_motion_ctrl #(
    parameter int unsigned X_MAX = 19,
    parameter int unsigned Y_MAX = 14,
    parameter int unsigned X_RST = 10,
    parameter int unsigned Y_RST = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [2:0] speed,
    input  logic       pause,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [4:0] cfg_x,
    input  logic [3:0] cfg_y,
    input  logic       cfg_dir_x,
    input  logic       cfg_dir_y,
    output logic [4:0] pos_x,
    output logic [3:0] pos_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       bounce_x,
    output logic       bounce_y,
    output logic       corner_hit,
    output logic [7:0] corner_count
);

    localparam logic [4:0] X_MAX_C = 5'(X_MAX);
    localparam logic [3:0] Y_MAX_C = 4'(Y_MAX);
    localparam logic [4:0] X_RST_C = 5'(X_RST);
    localparam logic [3:0] Y_RST_C = 4'(Y_RST);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_CALC   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic       load_s, step_s;
    logic [2:0] cnt_r;
    logic [4:0] nx_x_s, sh_x_r;
    logic [3:0] nx_y_s, sh_y_r;
    logic       nx_dx_s, nx_dy_s, nx_bx_s, nx_by_s;
    logic       sh_dx_r, sh_dy_r, sh_bx_r, sh_by_r;

    function automatic logic [4:0] clamp_x(input logic [4:0] v);
        return (v > X_MAX_C) ? X_MAX_C : v;
    endfunction

    function automatic logic [3:0] clamp_y(input logic [3:0] v);
        return (v > Y_MAX_C) ? Y_MAX_C : v;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_WAIT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; a config load takes priority over a frame tick
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        step_s  = 1'b0;
        case (state_r)
            ST_WAIT: begin
                if (cfg_valid) begin
                    load_s = 1'b1;
                end else if (frame_tick && !pause && (cnt_r == speed)) begin
                    step_s  = 1'b1;
                    state_s = ST_CALC;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_CALC:   state_s = ST_COMMIT;
            ST_COMMIT: state_s = ST_WAIT;
            default:   state_s = ST_WAIT;
        endcase
    end

    // Frame counter; wraps at 7 so a speed lowered below the count waits for the wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 3'd0;
        end else if (state_r == ST_WAIT) begin
            if (load_s || step_s) begin
                cnt_r <= 3'd0;
            end else if (frame_tick && !pause) begin
                cnt_r <= cnt_r + 3'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Next position per axis: a bounce flips direction and holds position for this step
    always_comb begin
        nx_x_s  = pos_x;
        nx_dx_s = dir_x;
        nx_bx_s = 1'b0;
        nx_y_s  = pos_y;
        nx_dy_s = dir_y;
        nx_by_s = 1'b0;
        if ((dir_x && (pos_x == X_MAX_C)) || (!dir_x && (pos_x == 5'd0))) begin
            nx_dx_s = ~dir_x;
            nx_bx_s = 1'b1;
        end else if (dir_x) begin
            nx_x_s = pos_x + 5'd1;
        end else begin
            nx_x_s = pos_x - 5'd1;
        end
        if ((dir_y && (pos_y == Y_MAX_C)) || (!dir_y && (pos_y == 4'd0))) begin
            nx_dy_s = ~dir_y;
            nx_by_s = 1'b1;
        end else if (dir_y) begin
            nx_y_s = pos_y + 4'd1;
        end else begin
            nx_y_s = pos_y - 4'd1;
        end
    end

    // Shadow registers captured in CALC so outputs stay stable until COMMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_x_r  <= 5'd0;
            sh_y_r  <= 4'd0;
            sh_dx_r <= 1'b0;
            sh_dy_r <= 1'b0;
            sh_bx_r <= 1'b0;
            sh_by_r <= 1'b0;
        end else if (state_r == ST_CALC) begin
            sh_x_r  <= nx_x_s;
            sh_y_r  <= nx_y_s;
            sh_dx_r <= nx_dx_s;
            sh_dy_r <= nx_dy_s;
            sh_bx_r <= nx_bx_s;
            sh_by_r <= nx_by_s;
        end else begin
            sh_x_r  <= sh_x_r;
            sh_y_r  <= sh_y_r;
            sh_dx_r <= sh_dx_r;
            sh_dy_r <= sh_dy_r;
            sh_bx_r <= sh_bx_r;
            sh_by_r <= sh_by_r;
        end
    end

    // Visible outputs: commit a step, apply a config load, or hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x        <= X_RST_C;
            pos_y        <= Y_RST_C;
            dir_x        <= 1'b1;
            dir_y        <= 1'b1;
            bounce_x     <= 1'b0;
            bounce_y     <= 1'b0;
            corner_hit   <= 1'b0;
            corner_count <= 8'd0;
            cfg_ready    <= 1'b1;
        end else begin
            bounce_x   <= 1'b0;
            bounce_y   <= 1'b0;
            corner_hit <= 1'b0;
            cfg_ready  <= (state_s == ST_WAIT);
            if (state_r == ST_COMMIT) begin
                pos_x      <= sh_x_r;
                pos_y      <= sh_y_r;
                dir_x      <= sh_dx_r;
                dir_y      <= sh_dy_r;
                bounce_x   <= sh_bx_r;
                bounce_y   <= sh_by_r;
                corner_hit <= sh_bx_r & sh_by_r;
                if (sh_bx_r && sh_by_r && (corner_count != 8'd255)) begin
                    corner_count <= corner_count + 8'd1;
                end else begin
                    corner_count <= corner_count;
                end
            end else if (load_s) begin
                pos_x <= clamp_x(cfg_x);
                pos_y <= clamp_y(cfg_y);
                dir_x <= cfg_dir_x;
                dir_y <= cfg_dir_y;
            end else begin
                pos_x <= pos_x;
                pos_y <= pos_y;
                dir_x <= dir_x;
                dir_y <= dir_y;
            end
        end
    end

endmodule

// File: tb/tb_dvd_motion_ctrl.sv
// Bench for dvd_motion_ctrl: directed vector table, hand-written corner sequences,
// and random traffic checked against a transaction-level model.
module tb_dvd_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic [2:0] speed = 3'd0;
    logic       pause = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [4:0] cfg_x = 5'd0;
    logic [3:0] cfg_y = 4'd0;
    logic       cfg_dir_x = 1'b0;
    logic       cfg_dir_y = 1'b0;
    logic       cfg_ready;
    logic [4:0] pos_x;
    logic [3:0] pos_y;
    logic       dir_x, dir_y, bounce_x, bounce_y, corner_hit;
    logic [7:0] corner_count;

    int n_checks = 0;
    int n_fail = 0;

    dvd_motion_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .speed(speed), .pause(pause),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_dir_x(cfg_dir_x), .cfg_dir_y(cfg_dir_y), .pos_x(pos_x), .pos_y(pos_y),
        .dir_x(dir_x), .dir_y(dir_y), .bounce_x(bounce_x), .bounce_y(bounce_y),
        .corner_hit(corner_hit), .corner_count(corner_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a step is planned when the qualifying tick is accepted and
    // becomes visible two edges later; while a step is in flight nothing is accepted.
    int m_x, m_y, m_cnt, m_cc, m_pending;
    bit m_dx, m_dy, m_bx, m_by, m_ch;
    int p_x, p_y;
    bit p_dx, p_dy, p_bx, p_by;

    function automatic void step_axis(input int p, input bit d, input int mx,
                                      output int np, output bit nd, output bit b);
        if ((d && p == mx) || (!d && p == 0)) begin
            np = p; nd = !d; b = 1'b1;
        end else begin
            np = d ? p + 1 : p - 1; nd = d; b = 1'b0;
        end
    endfunction

    task automatic model_reset();
        m_x = 10; m_y = 7; m_dx = 1; m_dy = 1; m_cnt = 0; m_cc = 0; m_pending = 0;
        m_bx = 0; m_by = 0; m_ch = 0;
    endtask

    task automatic model_edge();
        m_bx = 0; m_by = 0; m_ch = 0;
        if (m_pending == 1) begin
            m_x = p_x; m_y = p_y; m_dx = p_dx; m_dy = p_dy;
            m_bx = p_bx; m_by = p_by; m_ch = p_bx && p_by;
            if (m_ch) m_cc = (m_cc + 1 > 255) ? 255 : m_cc + 1;
            m_pending = 0;
        end else if (m_pending == 2) begin
            m_pending = 1;
        end else if (cfg_valid) begin
            m_x = (int'(cfg_x) > 19) ? 19 : int'(cfg_x);
            m_y = (int'(cfg_y) > 14) ? 14 : int'(cfg_y);
            m_dx = cfg_dir_x; m_dy = cfg_dir_y; m_cnt = 0;
        end else if (frame_tick && !pause) begin
            if (m_cnt == int'(speed)) begin
                m_cnt = 0;
                step_axis(m_x, m_dx, 19, p_x, p_dx, p_bx);
                step_axis(m_y, m_dy, 14, p_y, p_dy, p_by);
                m_pending = 2;
            end else begin
                m_cnt = (m_cnt + 1) % 8;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".pos_x"}, pos_x, m_x);
        check({tag, ".pos_y"}, pos_y, m_y);
        check({tag, ".dir_x"}, dir_x, m_dx);
        check({tag, ".dir_y"}, dir_y, m_dy);
        check({tag, ".bounce_x"}, bounce_x, m_bx);
        check({tag, ".bounce_y"}, bounce_y, m_by);
        check({tag, ".corner_hit"}, corner_hit, m_ch);
        check({tag, ".corner_count"}, corner_count, m_cc);
        check({tag, ".cfg_ready"}, cfg_ready, (m_pending == 0) ? 1 : 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic tick_wait();
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc(); cyc();
    endtask

    typedef struct {
        bit tk; bit cv; int cx; int cy; bit cdx; bit cdy;
        int ex; int ey; bit edx; bit edy; bit ebx; bit eby; bit ech; int ecc; bit erdy;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t row(bit tk, bit cv, int cx, int cy, bit cdx, bit cdy,
                                 int ex, int ey, bit edx, bit edy, bit ebx, bit eby,
                                 bit ech, int ecc, bit erdy);
        vec_t r;
        r.tk = tk; r.cv = cv; r.cx = cx; r.cy = cy; r.cdx = cdx; r.cdy = cdy;
        r.ex = ex; r.ey = ey; r.edx = edx; r.edy = edy; r.ebx = ebx; r.eby = eby;
        r.ech = ech; r.ecc = ecc; r.erdy = erdy;
        return r;
    endfunction

    initial begin
        // Each row: inputs before an edge, expected outputs after it (speed 0, no pause)
        tbl.push_back(row(1,0, 0, 0,0,0, 10, 7,1,1, 0,0,0, 0,0));
        tbl.push_back(row(0,0, 0, 0,0,0, 10, 7,1,1, 0,0,0, 0,0));
        tbl.push_back(row(0,0, 0, 0,0,0, 11, 8,1,1, 0,0,0, 0,1));
        tbl.push_back(row(1,0, 0, 0,0,0, 11, 8,1,1, 0,0,0, 0,0));
        tbl.push_back(row(0,0, 0, 0,0,0, 11, 8,1,1, 0,0,0, 0,0));
        tbl.push_back(row(0,0, 0, 0,0,0, 12, 9,1,1, 0,0,0, 0,1));
        tbl.push_back(row(1,0, 0, 0,0,0, 12, 9,1,1, 0,0,0, 0,0));
        tbl.push_back(row(0,0, 0, 0,0,0, 12, 9,1,1, 0,0,0, 0,0));
        tbl.push_back(row(0,0, 0, 0,0,0, 13,10,1,1, 0,0,0, 0,1));
        tbl.push_back(row(1,0, 0, 0,0,0, 13,10,1,1, 0,0,0, 0,0));
        tbl.push_back(row(1,0, 0, 0,0,0, 13,10,1,1, 0,0,0, 0,0));
        tbl.push_back(row(1,0, 0, 0,0,0, 14,11,1,1, 0,0,0, 0,1));
        tbl.push_back(row(0,0, 0, 0,0,0, 14,11,1,1, 0,0,0, 0,1));
        tbl.push_back(row(0,0, 0, 0,0,0, 14,11,1,1, 0,0,0, 0,1));
        tbl.push_back(row(0,1,19, 3,1,0, 19, 3,1,0, 0,0,0, 0,1));
        tbl.push_back(row(1,0, 0, 0,0,0, 19, 3,1,0, 0,0,0, 0,0));
        tbl.push_back(row(0,0, 0, 0,0,0, 19, 3,1,0, 0,0,0, 0,0));
        tbl.push_back(row(0,0, 0, 0,0,0, 19, 2,0,0, 1,0,0, 0,1));
        tbl.push_back(row(0,0, 0, 0,0,0, 19, 2,0,0, 0,0,0, 0,1));
        tbl.push_back(row(0,1, 0, 0,0,0,  0, 0,0,0, 0,0,0, 0,1));
        tbl.push_back(row(1,0, 0, 0,0,0,  0, 0,0,0, 0,0,0, 0,0));
        tbl.push_back(row(0,0, 0, 0,0,0,  0, 0,0,0, 0,0,0, 0,0));
        tbl.push_back(row(0,0, 0, 0,0,0,  0, 0,1,1, 1,1,1, 1,1));
        tbl.push_back(row(0,0, 0, 0,0,0,  0, 0,1,1, 0,0,0, 1,1));
        tbl.push_back(row(1,1,31,15,0,1, 19,14,0,1, 0,0,0, 1,1));
        tbl.push_back(row(0,0, 0, 0,0,0, 19,14,0,1, 0,0,0, 1,1));
        tbl.push_back(row(0,0, 0, 0,0,0, 19,14,0,1, 0,0,0, 1,1));

        repeat (2) @(negedge clk);
        model_reset();
        compare_model("reset");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            frame_tick = tbl[i].tk; cfg_valid = tbl[i].cv;
            cfg_x = 5'(tbl[i].cx); cfg_y = 4'(tbl[i].cy);
            cfg_dir_x = tbl[i].cdx; cfg_dir_y = tbl[i].cdy;
            cyc();
            check($sformatf("tbl%0d.pos_x", i), pos_x, tbl[i].ex);
            check($sformatf("tbl%0d.pos_y", i), pos_y, tbl[i].ey);
            check($sformatf("tbl%0d.dir_x", i), dir_x, tbl[i].edx);
            check($sformatf("tbl%0d.dir_y", i), dir_y, tbl[i].edy);
            check($sformatf("tbl%0d.bounce_x", i), bounce_x, tbl[i].ebx);
            check($sformatf("tbl%0d.bounce_y", i), bounce_y, tbl[i].eby);
            check($sformatf("tbl%0d.corner_hit", i), corner_hit, tbl[i].ech);
            check($sformatf("tbl%0d.corner_count", i), corner_count, tbl[i].ecc);
            check($sformatf("tbl%0d.cfg_ready", i), cfg_ready, tbl[i].erdy);
        end
        frame_tick = 1'b0; cfg_valid = 1'b0;

        // Repeated corner hits: count climbs from 1 and saturates at 255
        for (int i = 0; i < 300; i++) begin
            cfg_valid = 1'b1; cfg_x = 5'd0; cfg_y = 4'd0; cfg_dir_x = 1'b0; cfg_dir_y = 1'b0;
            cyc();
            cfg_valid = 1'b0;
            tick_wait();
            check("sat.corner_hit", corner_hit, 1);
            check("sat.corner_count", corner_count, (2 + i > 255) ? 255 : 2 + i);
        end
        compare_model("sat");

        // speed = 3: one step per four ticks; paused ticks freeze the counter
        cfg_valid = 1'b1; cfg_x = 5'd5; cfg_y = 4'd5; cfg_dir_x = 1'b1; cfg_dir_y = 1'b1;
        cyc();
        cfg_valid = 1'b0; speed = 3'd3;
        for (int t = 1; t <= 6; t++) begin
            tick_wait();
            check($sformatf("spd.tick%0d.pos_x", t), pos_x, (t >= 4) ? 6 : 5);
            check($sformatf("spd.tick%0d.pos_y", t), pos_y, (t >= 4) ? 6 : 5);
        end
        pause = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick_wait();
            check("pause.pos_x", pos_x, 6);
        end
        pause = 1'b0;
        tick_wait();
        check("resume1.pos_x", pos_x, 6);
        tick_wait();
        check("resume2.pos_x", pos_x, 7);
        check("resume2.pos_y", pos_y, 7);
        compare_model("spd");

        // Reset during CALC aborts the step
        speed = 3'd0;
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        check("calc.cfg_ready", cfg_ready, 0);
        rst_n = 1'b0;
        #1;
        check("rstcalc.pos_x", pos_x, 10);
        check("rstcalc.pos_y", pos_y, 7);
        check("rstcalc.dir_x", dir_x, 1);
        check("rstcalc.dir_y", dir_y, 1);
        check("rstcalc.corner_count", corner_count, 0);
        check("rstcalc.cfg_ready", cfg_ready, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("postrst.bounce_x", bounce_x, 0);
            check("postrst.pos_x", pos_x, 10);
            compare_model("postrst");
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            pause      = ($urandom_range(0, 5) == 0);
            cfg_valid  = ($urandom_range(0, 15) == 0);
            cfg_x      = 5'($urandom);
            cfg_y      = 4'($urandom);
            cfg_dir_x  = 1'($urandom);
            cfg_dir_y  = 1'($urandom);
            if ($urandom_range(0, 39) == 0) speed = 3'($urandom);
            cyc();
            compare_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
